// File: rtl/riscv_sb_pkg.sv
// Shared types and constants for the system-bus fabric between the LSU port and the
// peripheral slots.
package riscv_sb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } sb_state_t;

   localparam logic [31:0] SB_ERR_DATA = 32'hDEAD_BEEF;

   localparam int unsigned SLOT_UART_RX = 5;
   localparam int unsigned SLOT_UART_TX = 6;
   localparam int unsigned SLOT_TIMER   = 8;

   localparam int unsigned SB_SEL_MSB = 31;
   localparam int unsigned SB_SEL_LSB = 24;

endpackage

// File: rtl/riscv_sb_fabric_if.sv
// Upstream request/response and slot-side bus signals of the fabric.
// The slave modport is the fabric's view; master is the surrounding system.
interface riscv_sb_fabric_if #(
   parameter int unsigned NUM_SLOTS = 9
);
   logic                      req_i;
   logic                      we_i;
   logic [3:0]                be_i;
   logic [31:0]               addr_i;
   logic [31:0]               wd_i;
   logic [31:0]               rd_o;
   logic                      ready_o;
   logic                      err_o;
   logic [NUM_SLOTS-1:0]      slv_req_o;
   logic                      slv_we_o;
   logic [3:0]                slv_be_o;
   logic [31:0]               slv_addr_o;
   logic [31:0]               slv_wd_o;
   logic [32*NUM_SLOTS-1:0]   slv_rd_i;
   logic [NUM_SLOTS-1:0]      slv_ready_i;
   logic                      busy_o;

   modport slave (
      input  req_i, we_i, be_i, addr_i, wd_i, slv_rd_i, slv_ready_i,
      output rd_o, ready_o, err_o, slv_req_o, slv_we_o, slv_be_o, slv_addr_o, slv_wd_o,
             busy_o
   );

   modport master (
      output req_i, we_i, be_i, addr_i, wd_i, slv_rd_i, slv_ready_i,
      input  rd_o, ready_o, err_o, slv_req_o, slv_we_o, slv_be_o, slv_addr_o, slv_wd_o,
             busy_o
   );
endinterface

// File: rtl/sb_addr_decoder.sv
// Combinational slot decode: one-hot select of an enabled, in-range slot plus a mapped flag.
module sb_addr_decoder
   import riscv_sb_pkg::*;
#(
   parameter int unsigned          NUM_SLOTS = 9,
   parameter logic [NUM_SLOTS-1:0] SLOT_EN   = {NUM_SLOTS{1'b1}}
) (
   input  logic [SB_SEL_MSB-SB_SEL_LSB:0] i_sel,
   output logic                           o_mapped,
   output logic [NUM_SLOTS-1:0]           o_onehot
);

   always_comb begin
      o_onehot = '0;
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
         if ((32'(i_sel) == k) && SLOT_EN[k]) begin
            o_onehot[k] = 1'b1;
         end
      end
      o_mapped = |o_onehot;
   end

endmodule

// File: rtl/riscv_sb_fabric.sv
// System-bus fabric: registered IDLE/ACCESS/RESP handshake to one peripheral slot at a time,
// with unmapped-address and timeout error responses.
module riscv_sb_fabric
   import riscv_sb_pkg::*;
#(
   parameter int unsigned          NUM_SLOTS = 9,
   parameter logic [NUM_SLOTS-1:0] SLOT_EN   = {NUM_SLOTS{1'b1}},
   parameter int unsigned          TIMEOUT   = 255,
   parameter logic [31:0]          ERR_DATA  = SB_ERR_DATA
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   riscv_sb_fabric_if.slave        sb
);

   localparam int unsigned     CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   sb_state_t                  r_state;
   logic [CNT_W-1:0]           r_cnt;
   logic [NUM_SLOTS-1:0]       r_slv_req;
   logic                       r_we;
   logic [3:0]                 r_be;
   logic [SB_SEL_LSB-1:0]      r_addr;
   logic [31:0]                r_wd;
   logic [31:0]                r_rd;
   logic                       r_ready;
   logic                       r_err;

   logic                       w_mapped;
   logic [NUM_SLOTS-1:0]       w_onehot;
   logic [31:0]                w_sel_rd;
   logic                       w_sel_ready;
   logic                       w_expired;

   sb_addr_decoder #(
      .NUM_SLOTS (NUM_SLOTS),
      .SLOT_EN   (SLOT_EN)
   ) u_decoder (
      .i_sel    (sb.addr_i[SB_SEL_MSB:SB_SEL_LSB]),
      .o_mapped (w_mapped),
      .o_onehot (w_onehot)
   );

   // The latched one-hot request doubles as the slot select for data and ready.
   always_comb begin
      w_sel_rd = '0;
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
         if (r_slv_req[k]) begin
            w_sel_rd = sb.slv_rd_i[32*k +: 32];
         end
      end
   end

   assign w_sel_ready = |(sb.slv_ready_i & r_slv_req);
   assign w_expired   = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_slv_req <= '0;
         r_we      <= 1'b0;
         r_be      <= '0;
         r_addr    <= '0;
         r_wd      <= '0;
         r_rd      <= '0;
         r_ready   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (sb.req_i) begin
                  if (w_mapped) begin
                     r_slv_req <= w_onehot;
                     r_we      <= sb.we_i;
                     r_be      <= sb.be_i;
                     r_addr    <= sb.addr_i[SB_SEL_LSB-1:0];
                     r_wd      <= sb.wd_i;
                     r_state   <= ACCESS;
                  end else begin
                     r_rd    <= ERR_DATA;
                     r_err   <= 1'b1;
                     r_ready <= 1'b1;
                     r_state <= RESP;
                  end
               end
            end
            ACCESS: begin
               if (r_cnt != CNT_MAX) begin
                  r_cnt <= r_cnt + 1'b1;
               end
               // Ready takes priority over a timeout expiring on the same cycle.
               if (w_sel_ready) begin
                  r_rd      <= r_we ? 32'd0 : w_sel_rd;
                  r_err     <= 1'b0;
                  r_ready   <= 1'b1;
                  r_slv_req <= '0;
                  r_state   <= RESP;
               end else if (w_expired) begin
                  r_rd      <= ERR_DATA;
                  r_err     <= 1'b1;
                  r_ready   <= 1'b1;
                  r_slv_req <= '0;
                  r_state   <= RESP;
               end
            end
            RESP: begin
               r_err   <= 1'b0;
               r_cnt   <= '0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign sb.rd_o       = r_rd;
   assign sb.ready_o    = r_ready;
   assign sb.err_o      = r_err;
   assign sb.slv_req_o  = r_slv_req;
   assign sb.slv_we_o   = r_we;
   assign sb.slv_be_o   = r_be;
   assign sb.slv_addr_o = {{(32 - SB_SEL_LSB){1'b0}}, r_addr};
   assign sb.slv_wd_o   = r_wd;
   assign sb.busy_o     = (r_state != IDLE);

endmodule

// File: tb/tb_riscv_sb_fabric.sv
// Directed bench for riscv_sb_fabric: a transaction-level model predicts per-cycle outputs,
// plus literal spot checks at hand-computed cycles.
module tb_riscv_sb_fabric;

   localparam int unsigned NS     = 9;
   localparam int unsigned TO     = 4;
   localparam logic [8:0]  TB_EN  = 9'b1_1110_1111;
   localparam int          MAXC   = 128;
   localparam logic [31:0] ERRV   = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   riscv_sb_fabric_if #(.NUM_SLOTS(NS)) bus ();

   riscv_sb_fabric #(
      .NUM_SLOTS (NS),
      .SLOT_EN   (TB_EN),
      .TIMEOUT   (TO),
      .ERR_DATA  (ERRV)
   ) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .sb    (bus.slave)
   );

   // Slave ready schedule per cycle, and the expected per-cycle outputs.
   logic [8:0]  sched [MAXC];
   logic [8:0]  e_req [MAXC];
   logic        e_busy[MAXC];
   logic        e_rdy [MAXC];
   logic        e_err [MAXC];
   logic [31:0] e_rd  [MAXC];
   logic [31:0] e_addr[MAXC];
   logic        e_we  [MAXC];
   logic [3:0]  e_be  [MAXC];
   logic [31:0] e_wd  [MAXC];

   function automatic logic [31:0] slot_data(input int k);
      return (k == 6) ? 32'h0000_00A5 : 32'(32'h1111_1111 * k);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %h, want %h", name, cyc, act, exp);
      end
   endtask

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_neg(input int c);
      goto(c);
      @(negedge clk);
   endtask

   // Predict a request accepted in cycle t from the decode rules and the ready schedule.
   task automatic model_accept(input int t, input logic [31:0] addr, input logic we,
                               input logic [3:0] be, input logic [31:0] wd, output int resp);
      int          sel;
      logic        mapped;
      logic        err;
      logic [31:0] rdv;
      logic [8:0]  en;
      en     = TB_EN;
      sel    = int'(addr[31:24]);
      mapped = 1'b0;
      if (sel < int'(NS)) mapped = en[sel];
      err  = 1'b1;
      rdv  = ERRV;
      if (!mapped) begin
         resp = t + 1;
      end else begin
         resp = t + int'(TO) + 1;
         for (int c = t + 1; c <= t + int'(TO); c++) begin
            if (sched[c][sel]) begin
               resp = c + 1;
               err  = 1'b0;
               rdv  = we ? 32'd0 : slot_data(sel);
               break;
            end
         end
         for (int c = t + 1; c < resp; c++) begin
            e_req[c]  = 9'(1 << sel);
            e_addr[c] = {8'd0, addr[23:0]};
            e_we[c]   = we;
            e_be[c]   = be;
            e_wd[c]   = wd;
         end
      end
      for (int c = t + 1; c <= resp; c++) e_busy[c] = 1'b1;
      e_rdy[resp] = 1'b1;
      e_err[resp] = err;
      for (int c = resp; c < MAXC; c++) e_rd[c] = rdv;
   endtask

   task automatic model_reset(input int from);
      for (int c = from; c < MAXC; c++) begin
         e_req[c]  = '0;
         e_busy[c] = 1'b0;
         e_rdy[c]  = 1'b0;
         e_err[c]  = 1'b0;
         e_rd[c]   = '0;
      end
   endtask

   task automatic issue(input int t, input logic [31:0] addr, input logic we,
                        input logic [3:0] be, input logic [31:0] wd, output int resp);
      goto(t);
      bus.req_i  = 1'b1;
      bus.addr_i = addr;
      bus.we_i   = we;
      bus.be_i   = be;
      bus.wd_i   = wd;
      model_accept(t, addr, we, be, wd, resp);
      goto(t + 1);
      bus.req_i = 1'b0;
   endtask

   // Slave ready driver.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         bus.slv_ready_i = (cyc < MAXC) ? sched[cyc] : 9'd0;
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (cyc < MAXC) begin
         chk("slv_req_o", 32'(bus.slv_req_o), 32'(e_req[cyc]));
         chk("busy_o", 32'(bus.busy_o), 32'(e_busy[cyc]));
         chk("ready_o", 32'(bus.ready_o), 32'(e_rdy[cyc]));
         chk("rd_o", bus.rd_o, e_rd[cyc]);
         if (e_rdy[cyc]) chk("err_o", 32'(bus.err_o), 32'(e_err[cyc]));
         if (e_req[cyc] != 0) begin
            chk("slv_addr_o", bus.slv_addr_o, e_addr[cyc]);
            chk("slv_we_o", 32'(bus.slv_we_o), 32'(e_we[cyc]));
            chk("slv_be_o", 32'(bus.slv_be_o), 32'(e_be[cyc]));
            chk("slv_wd_o", bus.slv_wd_o, e_wd[cyc]);
         end
      end
   end

   initial begin
      int r;
      int r2;
      for (int c = 0; c < MAXC; c++) begin
         sched[c] = '0;
         e_req[c] = '0; e_busy[c] = 1'b0; e_rdy[c] = 1'b0; e_err[c] = 1'b0;
         e_rd[c] = '0; e_addr[c] = '0; e_we[c] = 1'b0; e_be[c] = '0; e_wd[c] = '0;
      end
      bus.req_i = 1'b0; bus.we_i = 1'b0; bus.be_i = '0; bus.addr_i = '0; bus.wd_i = '0;
      bus.slv_ready_i = '0;
      for (int k = 0; k < int'(NS); k++) bus.slv_rd_i[32*k +: 32] = slot_data(k);

      wait_neg(1);
      chk("reset rd_o", bus.rd_o, 32'd0);
      chk("reset busy_o", 32'(bus.busy_o), 32'd0);
      goto(3);
      rst_n = 1'b1;

      // Read slot 6, ready on the first ACCESS cycle.
      sched[6] = 9'h040;
      issue(5, 32'h0600_0010, 1'b0, 4'hF, 32'd0, r);
      wait_neg(6);
      chk("t1 slv_req", 32'(bus.slv_req_o), 32'h040);
      chk("t1 slv_addr", bus.slv_addr_o, 32'h0000_0010);
      wait_neg(7);
      chk("t1 ready", 32'(bus.ready_o), 32'd1);
      chk("t1 rd", bus.rd_o, 32'h0000_00A5);
      chk("t1 err", 32'(bus.err_o), 32'd0);

      // Write slot 8, ready three cycles late.
      sched[14] = 9'h100;
      issue(10, 32'h0800_0024, 1'b1, 4'b0011, 32'h1234_5678, r);
      wait_neg(14);
      chk("t2 slv_req", 32'(bus.slv_req_o), 32'h100);
      chk("t2 slv_wd", bus.slv_wd_o, 32'h1234_5678);
      chk("t2 slv_be", 32'(bus.slv_be_o), 32'h3);
      wait_neg(15);
      chk("t2 ready", 32'(bus.ready_o), 32'd1);
      chk("t2 err", 32'(bus.err_o), 32'd0);

      // Out-of-range slot, then a disabled slot.
      issue(20, 32'h0C00_0000, 1'b0, 4'hF, 32'd0, r);
      wait_neg(21);
      chk("t3 ready", 32'(bus.ready_o), 32'd1);
      chk("t3 err", 32'(bus.err_o), 32'd1);
      chk("t3 rd", bus.rd_o, 32'hDEAD_BEEF);
      issue(25, 32'h0400_0020, 1'b0, 4'hF, 32'd0, r);
      wait_neg(26);
      chk("t4 ready", 32'(bus.ready_o), 32'd1);
      chk("t4 err", 32'(bus.err_o), 32'd1);
      chk("t4 slv_req", 32'(bus.slv_req_o), 32'd0);

      // Slave never ready: timeout.
      issue(30, 32'h0500_0004, 1'b0, 4'hF, 32'd0, r);
      wait_neg(34);
      chk("t5 slv_req held", 32'(bus.slv_req_o), 32'h020);
      wait_neg(35);
      chk("t5 ready", 32'(bus.ready_o), 32'd1);
      chk("t5 err", 32'(bus.err_o), 32'd1);
      chk("t5 rd", bus.rd_o, 32'hDEAD_BEEF);

      // Ready on the expiry cycle wins.
      sched[44] = 9'h020;
      issue(40, 32'h0500_0008, 1'b0, 4'hF, 32'd0, r);
      wait_neg(45);
      chk("t6 ready", 32'(bus.ready_o), 32'd1);
      chk("t6 err", 32'(bus.err_o), 32'd0);
      chk("t6 rd", bus.rd_o, 32'h5555_5555);

      // Ready pulses from non-selected slots are ignored.
      sched[51] = 9'h140;
      sched[52] = 9'h001;
      sched[53] = 9'h020;
      issue(50, 32'h0500_000C, 1'b0, 4'hF, 32'd0, r);
      wait_neg(52);
      chk("t7 busy", 32'(bus.busy_o), 32'd1);
      wait_neg(54);
      chk("t7 ready", 32'(bus.ready_o), 32'd1);
      chk("t7 rd", bus.rd_o, 32'h5555_5555);

      // req_i held through RESP: second request accepted only in the next IDLE cycle.
      sched[61] = 9'h040;
      sched[64] = 9'h100;
      goto(60);
      bus.req_i = 1'b1; bus.addr_i = 32'h0600_0000; bus.we_i = 1'b0; bus.be_i = 4'hF;
      model_accept(60, 32'h0600_0000, 1'b0, 4'hF, bus.wd_i, r);
      goto(61);
      bus.addr_i = 32'h0800_0040;
      model_accept(r + 1, 32'h0800_0040, 1'b0, 4'hF, bus.wd_i, r2);
      goto(64);
      bus.req_i = 1'b0;
      wait_neg(64);
      chk("t8 second slv_req", 32'(bus.slv_req_o), 32'h100);
      wait_neg(65);
      chk("t8 second rd", bus.rd_o, 32'h8888_8888);

      // Asynchronous reset in the middle of ACCESS.
      issue(70, 32'h0500_0010, 1'b0, 4'hF, 32'd0, r);
      goto(72);
      #2;
      rst_n = 1'b0;
      model_reset(72);
      #1;
      chk("async slv_req", 32'(bus.slv_req_o), 32'd0);
      chk("async busy", 32'(bus.busy_o), 32'd0);
      chk("async ready", 32'(bus.ready_o), 32'd0);
      goto(75);
      rst_n = 1'b1;
      wait_neg(76);
      chk("post-reset rd", bus.rd_o, 32'd0);

      sched[79] = 9'h040;
      issue(78, 32'h0600_00FC, 1'b0, 4'hF, 32'd0, r);
      wait_neg(80);
      chk("t10 rd", bus.rd_o, 32'h0000_00A5);

      goto(86);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/riscv_sb_fabric.md
Name: riscv_sb_fabric

Overview:
- Parametrised system-bus fabric between the LSU-side memory port and up to NUM_SLOTS peripheral controllers (uart_rx, uart_tx, timer, ...).
- Successor to the fixed one-hot glue decode in the top level. Adds the following:
  - registered request/response FSM;
  - per-slot ready handshake;
  - slot-enable mask;
  - unmapped-address error;
  - bus timeout with error response.

Parameters:
- NUM_SLOTS, 9, number of peripheral slots; the slot index is addr_i[31:24], range 1..256.
- SLOT_EN, {NUM_SLOTS{1'b1}}, per-slot enable mask; a disabled slot decodes as unmapped.
- TIMEOUT, 255, maximum ACCESS cycles without slv_ready_i; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF, value returned on rd_o for every error response.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-low.
- req_i  in  1  upstream request.
- we_i  in  1  upstream write enable.
- be_i  in  4  upstream byte enables.
- addr_i  in  32  upstream address.
- wd_i  in  32  upstream write data.
- rd_o  out  32  response read data, registered.
- ready_o  out  1  one-cycle response-valid pulse.
- err_o  out  1  error flag, qualified by ready_o.
- slv_req_o  out  NUM_SLOTS  one-hot slot request.
- slv_we_o  out  1  write enable to slots.
- slv_be_o  out  4  byte enables to slots.
- slv_addr_o  out  32  slot-local address, {8'd0, addr[23:0]}.
- slv_wd_o  out  32  write data to slots.
- slv_rd_i  in  32*NUM_SLOTS  flattened slot read data; slot k occupies bits [32k+31:32k].
- slv_ready_i  in  NUM_SLOTS  per-slot ready.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - FSM goes to IDLE;
  - every output goes to 0, including rd_o=0, slv_req_o=0 and the timeout counter;
  - slv_req_o drops immediately, without waiting for a clock edge.
- All slave-side outputs come from registers captured at accept. They are stable for the whole ACCESS state.
- Decode: sel = addr_i[31:24]. mapped = (sel < NUM_SLOTS) && SLOT_EN[sel].
- FSM states: IDLE, ACCESS, RESP.
- IDLE, req_i=1 at edge N:
  - if mapped: latch we/be/addr/wd/sel, go to ACCESS at N+1;
  - if unmapped: go to RESP at N+1 with err=1 and rd=ERR_DATA. No slv_req_o is issued.
- ACCESS:
  - slv_req_o[sel]=1 and all other bits 0. It stays asserted until slv_ready_i[sel]=1.
  - On that cycle: capture the slv_rd_i[sel] slice into rd_o for reads (rd_o=0 for writes), err=0, go to RESP.
  - slv_ready_i bits of non-selected slots are ignored.
  - Counter increments each ACCESS cycle. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without ready: go to RESP with err=1, rd=ERR_DATA.
  - If ready and timeout expiry occur on the same cycle, ready wins (err=0).
- RESP:
  - ready_o=1 and err_o valid for exactly one cycle;
  - return to IDLE; counter clears.
- rd_o holds its value until the next response.
- Latency (accept edge to ready_o):
  - mapped access with a same-cycle slave ready: 2 cycles;
  - unmapped: 1 cycle;
  - timeout: TIMEOUT+1 cycles.
- req_i is ignored in ACCESS and RESP, and no queuing is done. The earliest next accept is the cycle after RESP (back-to-back period 3 cycles).
- Counter width is $clog2(TIMEOUT+1), minimum 1. It saturates and never wraps.

Decomposition:
- Package riscv_sb_pkg holds:
  - sb_state_t enum {IDLE, ACCESS, RESP};
  - ERR_DATA default;
  - slot constants SLOT_UART_RX=5, SLOT_UART_TX=6, SLOT_TIMER=8;
  - SB_SEL_MSB=31, SB_SEL_LSB=24.
- One sub-module, sb_addr_decoder: combinational sel/mapped/one-hot generation, parametrised by NUM_SLOTS and SLOT_EN.

Test Plan:
- Read slot 6, addr 32'h0600_0010, slave ready on the first ACCESS cycle, slv_rd=32'h0000_00A5 -> slv_req_o=9'b0_0100_0000 for 1 cycle, slv_addr_o=32'h0000_0010, ready_o 2 cycles after accept, rd_o=32'hA5, err_o=0.
- Write slot 8, be=4'b0011, wd=32'h1234_5678, ready delayed 3 cycles -> slv_req_o[8] held 4 cycles with stable we/be/wd, then ready_o=1, err_o=0.
- Access addr 32'h0C00_0000 (sel 12 >= NUM_SLOTS), and separately a slot with SLOT_EN bit cleared -> no slv_req_o, ready_o 1 cycle after accept, err_o=1, rd_o=32'hDEAD_BEEF.
- TIMEOUT=4, slave never ready -> slv_req_o high 4 cycles, then ready_o with err_o=1, rd_o=ERR_DATA. Repeat with ready arriving on the expiry cycle -> err_o=0.
- Non-selected slv_ready_i pulses during ACCESS to slot 5 -> ignored, FSM stays in ACCESS. req_i held through RESP -> second access accepted only in the following IDLE cycle.
- Assert rst_i=0 mid-ACCESS, asynchronously between edges -> slv_req_o, busy_o, ready_o drop immediately. After release, FSM is in IDLE and rd_o=0.
